// File: rtl/tone_osc_pkg.sv
// Shared types and constants for the tone_osc resonator.
// Build option: OSC_SAT_EN selects clamping plus a sticky sat_o flag instead of two's-complement wrap.
package tone_osc_pkg;

    typedef logic signed [15:0] sample_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int COEF_FRAC_DEF = 14;
    localparam int SAMPLE_MAX    = 32767;
    localparam int SAMPLE_MIN    = -32768;

    // Counter width for a divide-by-div counter; a single bit is kept for div == 1.
    function automatic int cnt_width(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/sample_tick_gen.sv
// Divide-by-DIV counter producing a one-cycle tick on its last count.
// clear has priority over en and forces the count back to zero.
module sample_tick_gen
    import tone_osc_pkg::*;
#(
    parameter int DIV = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic tick
);

    localparam int CW = cnt_width(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/tone_osc.sv
// Second-order recursive sine generator: y[n] = c*y[n-1] - y[n-2], one sample every DIV clocks.
// Build option: OSC_SAT_EN clamps the recursion result and adds the sticky sat_o output.
module tone_osc
    import tone_osc_pkg::*;
#(
    parameter int DIV       = 1000,
    parameter int COEF_FRAC = COEF_FRAC_DEF
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        start_i,
    input  logic        stop_i,
    input  logic [15:0] coef_i,
    input  logic [15:0] init_i,
    output logic [15:0] data_o,
    output logic        valid_o,
    output logic        busy_o
`ifdef OSC_SAT_EN
    ,
    output logic        sat_o
`endif
);

    // Handshake: valid_o is a one-cycle strobe; data_o holds the new sample during that cycle
    // and is stable until the next strobe. There is no back-pressure; the sink must accept every strobe.

    state_t  state_q, state_d;
    sample_t coef_q, y1_q, y2_q, y_d;
    logic    tick, sample_tick, cnt_clear, cnt_en;

    logic signed [31:0] p;
    logic signed [18:0] t;

    // Counter runs only in RUN and restarts from zero on any start or stop request.
    assign cnt_en    = (state_q == RUN);
    assign cnt_clear = start_i || stop_i || (state_q != RUN);

    sample_tick_gen #(
        .DIV(DIV)
    ) u_tick (
        .clk  (clk_i),
        .reset(reset_i),
        .clear(cnt_clear),
        .en   (cnt_en),
        .tick (tick)
    );

    always_comb begin
        state_d     = state_q;
        busy_o      = (state_q == RUN);
        sample_tick = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i && !stop_i) state_d = RUN;
            end
            RUN: begin
                if (stop_i) begin
                    state_d = IDLE;
                end else if (!start_i) begin
                    sample_tick = tick;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Floor-rounded Q2.14 multiply; 19 bits hold the full range of (p >>> 14) - y2.
    always_comb begin
        p = coef_q * y1_q;
        t = 19'(p >>> COEF_FRAC) - 19'(y2_q);
    end

`ifdef OSC_SAT_EN
    localparam logic signed [18:0] T_MAX = 19'(SAMPLE_MAX);
    localparam logic signed [18:0] T_MIN = 19'(SAMPLE_MIN);

    logic clamp;

    always_comb begin
        clamp = 1'b0;
        y_d   = sample_t'(t);
        if (t > T_MAX) begin
            clamp = 1'b1;
            y_d   = sample_t'(SAMPLE_MAX);
        end else if (t < T_MIN) begin
            clamp = 1'b1;
            y_d   = sample_t'(SAMPLE_MIN);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sat_o <= 1'b0;
        end else if (start_i && !stop_i) begin
            sat_o <= 1'b0;
        end else if (sample_tick && clamp) begin
            sat_o <= 1'b1;
        end
    end
`else
    assign y_d = sample_t'(t);
`endif

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            coef_q  <= '0;
            y1_q    <= '0;
            y2_q    <= '0;
            data_o  <= '0;
            valid_o <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_o <= 1'b0;
            if (stop_i) begin
                y1_q   <= '0;
                y2_q   <= '0;
                data_o <= '0;
            end else if (start_i) begin
                coef_q <= coef_i;
                y1_q   <= init_i;
                y2_q   <= '0;
                data_o <= '0;
            end else if (sample_tick) begin
                y2_q    <= y1_q;
                y1_q    <= y_d;
                data_o  <= y_d;
                valid_o <= 1'b1;
            end
        end
    end

endmodule
